// File: rtl/mem_port_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t SERVE_I = 3'd1;
  localparam state_t SERVE_D = 3'd2;
  localparam state_t DONE_I  = 3'd3;
  localparam state_t DONE_D  = 3'd4;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Operands captured at grant time and replayed onto the memory port.
  typedef struct packed {
    logic        we;
    logic        misal;
    logic [2:0]  func3;
    logic [31:0] wdata;
  } xact_t;

endpackage

// File: rtl/mem_align_check.sv
// Combinational misalignment detector for RISC-V halfword/word accesses.
module mem_align_check
  import mem_port_pkg::*;
(
  input  logic [2:0] func3,
  input  logic [1:0] addr,   // only the low address bits matter
  output logic       misaligned
);

  always_comb begin
    misaligned = 1'b0;
    case (func3)
      LH, LHU: misaligned = addr[0];
      LW:      misaligned = |addr;
      default: misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter onto one single-cycle memory port, 3 cycles per access.
// Define MEM_ALIGN_CHECK_EN to suppress and flag misaligned accesses.
module mem_port_arbiter
  import mem_port_pkg::*;
#(
  parameter int ADDR_W          = 8,
  parameter int DATA_STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_func3,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_func3,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(DATA_STREAK_MAX + 1);

  state_t            state;
  logic [CNT_W-1:0]  streak_cnt;
  logic [ADDR_W-1:0] lat_addr;
  xact_t             lat;

  logic              streak_full, grant_d, grant_i, serving;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_func3;
  logic              sel_misal;

  assign streak_full = (streak_cnt == CNT_W'(DATA_STREAK_MAX));
  // Data wins by default; a saturated streak hands one slot to a waiting fetch.
  assign grant_d   = (state == IDLE) && d_req && !(if_req && streak_full);
  assign grant_i   = (state == IDLE) && if_req && !grant_d;
  assign sel_addr  = grant_d ? d_addr  : if_addr;
  assign sel_func3 = grant_d ? d_func3 : LW;

`ifdef MEM_ALIGN_CHECK_EN
  mem_align_check u_align (
    .func3      (sel_func3),
    .addr       (sel_addr[1:0]),
    .misaligned (sel_misal)
  );
  assign d_err = (state == DONE_D) && lat.misal;
`else
  assign sel_misal = 1'b0;
  assign d_err     = 1'b0;
`endif

  // Port outputs decode from state so an async reset silences them at once.
  assign serving   = (state == SERVE_I) || (state == SERVE_D);
  assign mem_read  = serving && !lat.we && !lat.misal;
  assign mem_write = serving &&  lat.we && !lat.misal;
  assign mem_addr  = serving ? lat_addr  : '0;
  assign mem_func3 = serving ? lat.func3 : 3'b000;
  assign mem_wdata = serving ? lat.wdata : 32'h0;
  assign if_ack    = (state == DONE_I);
  assign d_ack     = (state == DONE_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      streak_cnt <= '0;
      lat_addr   <= '0;
      lat        <= '0;
      if_rdata   <= 32'h0;
      d_rdata    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= SERVE_D;
            lat_addr  <= sel_addr;
            lat.we    <= d_we;
            lat.misal <= sel_misal;
            lat.func3 <= sel_func3;
            lat.wdata <= d_wdata;
            if (!if_req)          streak_cnt <= '0;
            else if (!streak_full) streak_cnt <= streak_cnt + 1'b1;
          end else if (grant_i) begin
            state      <= SERVE_I;
            lat_addr   <= sel_addr;
            lat.we     <= 1'b0;
            lat.misal  <= sel_misal;
            lat.func3  <= sel_func3;
            lat.wdata  <= 32'h0;
            streak_cnt <= '0;
          end
        end
        SERVE_I: begin
          if_rdata <= lat.misal ? 32'h0 : mem_rdata;
          state    <= DONE_I;
        end
        SERVE_D: begin
          d_rdata <= (lat.we || lat.misal) ? 32'h0 : mem_rdata;
          state   <= DONE_D;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a byte-addressed memory model.
module tb_mem_port_arbiter;
  import mem_port_pkg::*;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_ack;
  logic [7:0]  if_addr;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_ack, d_err;
  logic [7:0]  d_addr;
  logic [2:0]  d_func3;
  logic [31:0] d_wdata, d_rdata;
  logic        mem_read, mem_write;
  logic [7:0]  mem_addr;
  logic [2:0]  mem_func3;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .DATA_STREAK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_func3(d_func3), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_func3(mem_func3), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: little-endian bytes, sign/zero extension by funct3
  logic [7:0] mem [256];
  logic       mem_clear;
  logic [7:0] b0, b1, b2, b3;
  assign b0 = mem[mem_addr];
  assign b1 = mem[mem_addr + 8'd1];
  assign b2 = mem[mem_addr + 8'd2];
  assign b3 = mem[mem_addr + 8'd3];

  function automatic logic [31:0] load_val(input logic [7:0] x0, x1, x2, x3, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{x0[7]}}, x0};
      3'b001:  return {{16{x1[7]}}, x1, x0};
      3'b100:  return {24'h0, x0};
      3'b101:  return {16'h0, x1, x0};
      default: return {x3, x2, x1, x0};
    endcase
  endfunction

  assign mem_rdata = mem_read ? load_val(b0, b1, b2, b3, mem_func3) : 32'hA5A5A5A5;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[0] <= 8'h2A; mem[1] <= 8'h01; mem[2] <= 8'h0F; mem[3] <= 8'h13;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata[7:0];
      if (mem_func3 != 3'b000) mem[mem_addr + 8'd1] <= mem_wdata[15:8];
      if (mem_func3 == 3'b010) begin
        mem[mem_addr + 8'd2] <= mem_wdata[23:16];
        mem[mem_addr + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  int         rd_cnt = 0, wr_cnt = 0;
  logic [2:0] last_wf3 = 3'b111;
  always @(posedge clk) begin
    if (mem_read)  rd_cnt <= rd_cnt + 1;
    if (mem_write) begin
      wr_cnt   <= wr_cnt + 1;
      last_wf3 <= mem_func3;
    end
  end

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t        dq [$];
  logic [31:0] iq [$];
  logic        kq [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_data(input logic we, input logic [7:0] addr, input logic [2:0] f3,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_mc, input string nm);
    exp_t e;
    int   n, r0, w0;
    bit   got;
    e.rdata = exp_rd; e.err = exp_err;
    dq.push_back(e);
    r0 = rd_cnt; w0 = wr_cnt;
    d_we = we; d_addr = addr; d_func3 = f3; d_wdata = wdata; d_req = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      @(posedge clk); @(negedge clk);
      n++;
      got = d_ack;
    end
    e = dq.pop_front();
    if (!got) chk({nm, " ack timeout"}, 32'd0, 32'd1);
    else begin
      chk({nm, " rdata"}, d_rdata, e.rdata);
      chk({nm, " err"}, 32'(d_err), 32'(e.err));
      chk({nm, " latency"}, n, 2);
      chk({nm, " mem cycles"}, (rd_cnt - r0) + (wr_cnt - w0), exp_mc);
      if (we && exp_mc == 1) chk({nm, " write func3"}, 32'(last_wf3), 32'(f3));
    end
    d_req = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic do_fetch(input logic [7:0] addr, input logic [31:0] exp_rd, input int exp_mc,
                          input string nm);
    logic [31:0] e;
    int          n, r0;
    bit          got;
    iq.push_back(exp_rd);
    r0 = rd_cnt;
    if_addr = addr; if_req = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      @(posedge clk); @(negedge clk);
      n++;
      got = if_ack;
    end
    e = iq.pop_front();
    if (!got) chk({nm, " ack timeout"}, 32'd0, 32'd1);
    else begin
      chk({nm, " rdata"}, if_rdata, e);
      chk({nm, " latency"}, n, 2);
      chk({nm, " mem reads"}, rd_cnt - r0, exp_mc);
    end
    if_req = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          mcyc;
  } vec_t;
  vec_t tbl [15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, ic, acks;
    exp_t e;
    logic exp_k;

    tbl = '{
      '{1'b1, 8'h1B, SB,  32'h123456AB, 32'h00000000, 1'b0, 1},
      '{1'b0, 8'h1B, LBU, 32'h0,        32'h000000AB, 1'b0, 1},
      '{1'b0, 8'h1B, LB,  32'h0,        32'hFFFFFFAB, 1'b0, 1},
      '{1'b1, 8'h20, SW,  32'hDEADBEEF, 32'h00000000, 1'b0, 1},
      '{1'b0, 8'h20, LW,  32'h0,        32'hDEADBEEF, 1'b0, 1},
      '{1'b0, 8'h22, LH,  32'h0,        32'hFFFFDEAD, 1'b0, 1},
      '{1'b0, 8'h20, LHU, 32'h0,        32'h0000BEEF, 1'b0, 1},
      '{1'b1, 8'h30, SH,  32'h00008001, 32'h00000000, 1'b0, 1},
      '{1'b0, 8'h30, LW,  32'h0,        32'h00008001, 1'b0, 1},
      '{1'b1, 8'h04, SW,  32'h11223344, 32'h00000000, 1'b0, 1},
      '{1'b1, 8'h08, SW,  32'h55667788, 32'h00000000, 1'b0, 1},
      '{1'b0, 8'h05, LW,  32'h0,        ALIGN ? 32'h0 : 32'h88112233, ALIGN, ALIGN ? 0 : 1},
      '{1'b0, 8'h21, LH,  32'h0,        ALIGN ? 32'h0 : 32'hFFFFADBE, ALIGN, ALIGN ? 0 : 1},
      '{1'b1, 8'h31, SH,  32'h00007777, 32'h00000000, ALIGN, ALIGN ? 0 : 1},
      '{1'b0, 8'h30, LW,  32'h0,        ALIGN ? 32'h00008001 : 32'h00777701, 1'b0, 1}
    };

    rst_n = 1'b0; mem_clear = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_func3 = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset mem_read",  32'(mem_read),  32'd0);
    chk("reset mem_write", 32'(mem_write), 32'd0);
    chk("reset mem_addr",  32'(mem_addr),  32'd0);
    chk("reset if_ack",    32'(if_ack),    32'd0);
    chk("reset d_ack",     32'(d_ack),     32'd0);
    chk("reset d_err",     32'(d_err),     32'd0);
    chk("reset if_rdata",  if_rdata,       32'd0);
    chk("reset d_rdata",   d_rdata,        32'd0);
    rst_n = 1'b1; mem_clear = 1'b0;

    do_fetch(8'h00, 32'h130F012A, 1, "fetch0");

    for (int i = 0; i < 15; i++)
      do_data(tbl[i].we, tbl[i].addr, tbl[i].f3, tbl[i].wdata, tbl[i].rdata, tbl[i].err,
              tbl[i].mcyc, $sformatf("vec%0d", i));

    do_fetch(8'h02, ALIGN ? 32'h0 : 32'h3344130F, ALIGN ? 0 : 1, "fetch misaligned");
    chk("d_rdata hold", d_rdata, tbl[14].rdata);

    // Simultaneous requests: data first, fetch three cycles later
    e.rdata = 32'h11223344; e.err = 1'b0;
    dq.push_back(e);
    iq.push_back(32'h55667788);
    d_we = 1'b0; d_addr = 8'h04; d_func3 = LW; d_req = 1'b1;
    if_addr = 8'h08; if_req = 1'b1;
    dc = -1; ic = -1;
    for (int cyc = 1; cyc <= 20 && ic < 0; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (d_ack && dq.size() > 0) begin
        e = dq.pop_front();
        chk("simul d_rdata", d_rdata, e.rdata);
        dc = cyc; d_req = 1'b0;
      end
      if (if_ack && iq.size() > 0) begin
        chk("simul if_rdata", if_rdata, iq.pop_front());
        ic = cyc; if_req = 1'b0;
      end
    end
    chk("simul d_ack cycle", dc, 2);
    chk("simul if_ack gap", ic - dc, 3);
    d_req = 1'b0; if_req = 1'b0;
    dq.delete(); iq.delete();
    @(posedge clk); @(negedge clk);

    // Streak limit: both held, four data grants then one fetch
    for (int k = 0; k < 10; k++) kq.push_back(k % 5 == 4);
    d_we = 1'b0; d_addr = 8'h00; d_func3 = LW; d_req = 1'b1;
    if_addr = 8'h00; if_req = 1'b1;
    acks = 0;
    for (int cyc = 0; cyc < 60 && acks < 10; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (d_ack || if_ack) begin
        exp_k = kq.pop_front();
        chk($sformatf("streak grant %0d is fetch", acks), 32'(if_ack), 32'(exp_k));
        acks++;
        if (acks == 10) begin d_req = 1'b0; if_req = 1'b0; end
      end
    end
    chk("streak ack count", acks, 10);
    d_req = 1'b0; if_req = 1'b0;
    @(posedge clk); @(negedge clk);

    // Reset in the middle of a store
    d_we = 1'b1; d_addr = 8'h0C; d_func3 = SW; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("serve store mem_write", 32'(mem_write), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("reset drops mem_write", 32'(mem_write), 32'd0);
    chk("reset drops mem_addr",  32'(mem_addr),  32'd0);
    @(posedge clk); @(negedge clk);
    chk("reset store suppressed", {mem[8'h0F], mem[8'h0E], mem[8'h0D], mem[8'h0C]}, 32'h0);
    d_req = 1'b0; d_we = 1'b0;
    rst_n = 1'b1;
    acks = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (d_ack || if_ack) acks++;
    end
    chk("no ack after reset", acks, 0);
    chk("d_rdata cleared by reset", d_rdata, 32'h0);
    do_data(1'b0, 8'h0C, LW, 32'h0, 32'h0, 1'b0, 1, "post-reset load");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
